ram32_arbiter: RTL
==================

RAM32_ARBITER -- requirements
Module: ram32_arbiter

Interface
REQ-001 Parameter BITS, default 5, RAM address width; depth 2**BITS entries of 64 bits.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous, active-high; one clock domain.
REQ-004 a_valid, b_valid  in  1  requester A/B port-0 request.
REQ-005 a_ready, b_ready  out  1  grant; request accepted in the cycle where valid & ready.
REQ-006 a_we, b_we  in  8  byte write mask; 0 = read, nonzero = write.
REQ-007 a_addr, b_addr  in  BITS  entry address.
REQ-008 a_wdata, b_wdata  in  64  write data.
REQ-009 a_rvalid, b_rvalid  out  1  read response valid; a_rdata, b_rdata  out  64  read data.
REQ-010 rd_valid  in  1, rd_addr  in  BITS  read-only port-1 request, always accepted in RUN.
REQ-011 rd_data_valid  out  1, rd_data  out  64  port-1 response.
REQ-012 init_done  out  1  high once RAM clear complete.
REQ-013 RAM side: ram_en0, ram_a0[BITS], ram_we0[8], ram_di0[64] out; ram_do0[64] in; ram_en1, ram_a1[BITS] out; ram_do1[64] in; RAM read data is registered, one cycle after enable.

Function
REQ-014 FSM states INIT, RUN; INIT entered on reset.
REQ-015 INIT: counter 0..2**BITS-1, one entry per cycle: ram_en0=1, ram_we0=0xFF, ram_di0=0, ram_a0=counter; a_ready=b_ready=0; rd_valid ignored (ram_en1=0).
REQ-016 INIT -> RUN in the cycle after counter writes entry 2**BITS-1; init_done rises with RUN (INIT lasts exactly 2**BITS cycles after rst deasserts).
REQ-017 RUN, one valid: that requester granted same cycle (ready combinational from valid and state).
REQ-018 RUN, both valid: round-robin; requester not granted last in a contention-free or contended grant wins; pointer after reset favours A.
REQ-019 Pointer updates only on an actual grant.
REQ-020 Granted request drives ram_en0=1, ram_a0, ram_we0, ram_di0 from the winner; no grant -> ram_en0=0, ram_we0=0.
REQ-021 Granted read (we=0): winner's rvalid=1 exactly one cycle later, rdata=ram_do0; rvalid deasserts otherwise; loser's rvalid stays 0.
REQ-022 Granted write: no response; rvalid stays 0.
REQ-023 RUN port 1: rd_valid -> ram_en1=1, ram_a1=rd_addr; rd_data_valid=1 next cycle, rd_data per REQ-029/030.
REQ-024 Port-0 and port-1 operations fully concurrent; no throughput loss.
REQ-025 Back-to-back requests: one per cycle, latency fixed at 1.

Reset
REQ-026 rst high: all outputs 0 (ready, rvalid, rd_data_valid, init_done, ram enables/we); rdata/rd_data 0.
REQ-027 rst mid-RUN: in-flight responses discarded (no rvalid/rd_data_valid the following cycle), pointer to A, INIT restarts at entry 0.
REQ-028 rst mid-INIT: counter restarts at 0.

Configuration
REQ-029 BYPASS_EN defined: port-1 read to the address written by port 0 in the same cycle returns, next cycle, bytes with ram_we0 set from ram_di0 and remaining bytes from ram_do1; bypass also applies during INIT (returns 0) only if rd_valid is honoured, which it is not (REQ-015).
REQ-030 BYPASS_EN undefined: rd_data = ram_do1 unmodified (old contents on same-cycle collision); no bypass registers.

Verification
REQ-031 Reset, then 32 cycles: init_done=0 throughout, ram_a0 0..31 with we=0xFF, di=0; init_done=1 on cycle 33; port-1 read addr 7 -> rd_data=0.
REQ-032 A and B valid every cycle, A writes addr 1 (we=0xFF), B reads addr 2: grants alternate A,B,A,B; B rvalid one cycle after each B grant.
REQ-033 A writes 0x1122334455667788 to addr 5, then A reads addr 5 -> a_rvalid next cycle, a_rdata=0x1122334455667788; b_rvalid=0.
REQ-034 Addr 3 = 0xFFFF...FF; same cycle A writes 0x00 with we=0x0F to addr 3 and rd_addr=3: BYPASS_EN -> rd_data=0xFFFFFFFF00000000; without -> 0xFFFFFFFFFFFFFFFF.
REQ-035 A read granted, rst asserted next cycle: a_rvalid stays 0, ready low, INIT restarts at entry 0, pointer favours A after init.

Source files
------------

// File: rtl/ram32_arbiter_if.sv
// Request/response bundle for ram32_arbiter: two arbitrated port-0 requesters (A, B)
// and the read-only port-1 channel.
interface ram32_arbiter_if #(parameter int BITS = 5);
   logic            a_valid;
   logic            a_ready;
   logic [7:0]      a_we;
   logic [BITS-1:0] a_addr;
   logic [63:0]     a_wdata;
   logic            a_rvalid;
   logic [63:0]     a_rdata;

   logic            b_valid;
   logic            b_ready;
   logic [7:0]      b_we;
   logic [BITS-1:0] b_addr;
   logic [63:0]     b_wdata;
   logic            b_rvalid;
   logic [63:0]     b_rdata;

   logic            rd_valid;
   logic [BITS-1:0] rd_addr;
   logic            rd_data_valid;
   logic [63:0]     rd_data;

   modport master (
      output a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata, rd_valid, rd_addr,
      input  a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata, rd_data_valid, rd_data
   );

   modport slave (
      input  a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata, rd_valid, rd_addr,
      output a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata, rd_data_valid, rd_data
   );
endinterface

// File: rtl/ram32_arbiter.sv
// Two-requester round-robin arbiter for port 0 of a 64-bit dual-port RAM, with RAM clear
// after reset and a read-only port 1. Define BYPASS_EN to forward same-cycle port-0 writes to port-1 reads.
module ram32_arbiter #(
   parameter int BITS = 5
) (
   input  logic            clk,
   input  logic            rst,
   ram32_arbiter_if.slave  bus,
   output logic            init_done,
   output logic            ram_en0,
   output logic [BITS-1:0] ram_a0,
   output logic [7:0]      ram_we0,
   output logic [63:0]     ram_di0,
   input  logic [63:0]     ram_do0,
   output logic            ram_en1,
   output logic [BITS-1:0] ram_a1,
   input  logic [63:0]     ram_do1
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [BITS-1:0] LAST_ENTRY = '1;

   state_t          state_reg;
   logic [BITS-1:0] cnt_reg;
   logic            prio_b_reg;
   logic            init_done_reg;
   logic            a_rvalid_reg;
   logic            b_rvalid_reg;
   logic            rd_valid_reg;

   logic            run;
   logic            grant_a;
   logic            grant_b;
   logic            rd_en;
   logic [63:0]     rd_word;

   // Reset gates every request path combinationally so nothing escapes while rst is high.
   always_comb begin
      run     = (state_reg == RUN) && !rst;
      grant_a = run && bus.a_valid && (!bus.b_valid || !prio_b_reg);
      grant_b = run && bus.b_valid && (!bus.a_valid || prio_b_reg);
      rd_en   = run && bus.rd_valid;
   end

   always_comb begin
      ram_en0 = 1'b0;
      ram_a0  = '0;
      ram_we0 = 8'h00;
      ram_di0 = 64'h0;
      if (!rst && state_reg == INIT) begin
         ram_en0 = 1'b1;
         ram_a0  = cnt_reg;
         ram_we0 = 8'hFF;
      end else if (grant_a) begin
         ram_en0 = 1'b1;
         ram_a0  = bus.a_addr;
         ram_we0 = bus.a_we;
         ram_di0 = bus.a_wdata;
      end else if (grant_b) begin
         ram_en0 = 1'b1;
         ram_a0  = bus.b_addr;
         ram_we0 = bus.b_we;
         ram_di0 = bus.b_wdata;
      end
   end

   assign ram_en1 = rd_en;
   assign ram_a1  = rd_en ? bus.rd_addr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= INIT;
         cnt_reg       <= '0;
         prio_b_reg    <= 1'b0;
         init_done_reg <= 1'b0;
         a_rvalid_reg  <= 1'b0;
         b_rvalid_reg  <= 1'b0;
         rd_valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_ENTRY) begin
                  state_reg     <= RUN;
                  init_done_reg <= 1'b1;
               end
            end
            RUN: begin
               // The requester just served loses the next tie.
               if (grant_a)
                  prio_b_reg <= 1'b1;
               else if (grant_b)
                  prio_b_reg <= 1'b0;
            end
            default: state_reg <= INIT;
         endcase
         a_rvalid_reg <= grant_a && (bus.a_we == 8'h00);
         b_rvalid_reg <= grant_b && (bus.b_we == 8'h00);
         rd_valid_reg <= rd_en;
      end
   end

`ifdef BYPASS_EN
   logic [7:0]  byp_mask_reg;
   logic [63:0] byp_data_reg;
   genvar gi;

   // Capture which bytes port 0 wrote to the address port 1 is reading this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_mask_reg <= 8'h00;
         byp_data_reg <= 64'h0;
      end else begin
         byp_mask_reg <= (rd_en && ram_en0 && ram_a0 == bus.rd_addr) ? ram_we0 : 8'h00;
         byp_data_reg <= ram_di0;
      end
   end

   for (gi = 0; gi < 8; gi++) begin : g_byp
      assign rd_word[gi*8 +: 8] = byp_mask_reg[gi] ? byp_data_reg[gi*8 +: 8] : ram_do1[gi*8 +: 8];
   end
`else
   assign rd_word = ram_do1;
`endif

   assign init_done         = init_done_reg && !rst;
   assign bus.a_ready       = grant_a;
   assign bus.b_ready       = grant_b;
   assign bus.a_rvalid      = a_rvalid_reg && !rst;
   assign bus.b_rvalid      = b_rvalid_reg && !rst;
   assign bus.a_rdata       = bus.a_rvalid ? ram_do0 : 64'h0;
   assign bus.b_rdata       = bus.b_rvalid ? ram_do0 : 64'h0;
   assign bus.rd_data_valid = rd_valid_reg && !rst;
   assign bus.rd_data       = bus.rd_data_valid ? rd_word : 64'h0;

endmodule
